// File: rtl/cv32e40x_pkg.sv
// Shared cv32e40x definitions: AES32 custom-0 encodings and XIF offload types.
package cv32e40x_pkg;

    // AES32 instructions live in the custom-0 opcode space
    localparam logic [6:0] OPCODE_CUSTOM_0  = 7'b0001011;
    localparam logic [2:0] FUNCT3_AES32     = 3'b000;
    localparam logic [6:0] FUNCT7_AES32ESI  = 7'b0010001;
    localparam logic [6:0] FUNCT7_AES32ESMI = 7'b0010011;
    localparam logic [6:0] FUNCT7_AES32DSI  = 7'b0010101;
    localparam logic [6:0] FUNCT7_AES32DSMI = 7'b0010111;

    // Both rs operands are always supplied with an offload issue
    localparam logic [1:0] XIF_RS_VALID_2OP = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMMIT,
        WAIT_RES
    } xif_offload_state_e;

    // Build an R-type AES32 instruction word
    function automatic logic [31:0] aes32_instr(input logic [6:0] funct7,
                                                input logic [4:0] rs2,
                                                input logic [4:0] rs1,
                                                input logic [4:0] rd);
        return {funct7, rs2, rs1, FUNCT3_AES32, rd, OPCODE_CUSTOM_0};
    endfunction

endpackage

// File: rtl/cv32e40x_xif_watchdog.sv
// Result watchdog: cleared on load, counts while enabled, flags expiry on the Limit-th cycle.
module cv32e40x_xif_watchdog #(
    parameter int unsigned Limit = 1024
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (Limit > 2) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/cv32e40x_xif_offload.sv
// Core-side XIF initiator for custom-0 offload: issue, commit, result, one instruction in flight.
// Optional result watchdog enabled by defining XIF_OFFLOAD_TIMEOUT_EN.
module cv32e40x_xif_offload
    import cv32e40x_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_RFR_WIDTH    = 32,
    parameter int unsigned X_RFW_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_instr_i,
    input  logic [X_RFR_WIDTH-1:0]   req_rs1_i,
    input  logic [X_RFR_WIDTH-1:0]   req_rs2_i,
    input  logic                     pipe_commit_i,
    input  logic                     pipe_kill_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [31:0]              issue_instr_o,
    output logic [X_ID_WIDTH-1:0]    issue_id_o,
    output logic [2*X_RFR_WIDTH-1:0] issue_rs_o,
    output logic [1:0]               issue_rs_valid_o,
    input  logic                     issue_accept_i,
    output logic                     commit_valid_o,
    output logic [X_ID_WIDTH-1:0]    commit_id_o,
    output logic                     commit_kill_o,
    input  logic                     result_valid_i,
    output logic                     result_ready_o,
    input  logic [X_ID_WIDTH-1:0]    result_id_i,
    input  logic [4:0]               result_rd_i,
    input  logic                     result_we_i,
    input  logic [X_RFW_WIDTH-1:0]   result_data_i,
    output logic                     wb_valid_o,
    output logic [4:0]               wb_rd_o,
    output logic [X_RFW_WIDTH-1:0]   wb_data_o,
    output logic                     illegal_o,
    output logic                     timeout_o
);

    xif_offload_state_e state_q, state_d;

    logic [X_ID_WIDTH-1:0]  id_q, id_d;
    logic [X_ID_WIDTH-1:0]  inflight_id_q, inflight_id_d;
    logic                   kill_pend_q, kill_pend_d;
    logic [31:0]            instr_q, instr_d;
    logic [X_RFR_WIDTH-1:0] rs1_q, rs1_d;
    logic [X_RFR_WIDTH-1:0] rs2_q, rs2_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic [X_RFW_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                   illegal_q, illegal_d;
    // Low only while in reset, so result_ready_o stays 0 until reset is released
    logic                   active_q;
    logic                   wd_expire;

`ifdef XIF_OFFLOAD_TIMEOUT_EN
    cv32e40x_xif_watchdog #(
        .Limit (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clear_i  (state_q == COMMIT),
        .en_i     (state_q == WAIT_RES),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state, handshake outputs and captured payload/result
    always_comb begin
        state_d          = state_q;
        id_d             = id_q;
        inflight_id_d    = inflight_id_q;
        kill_pend_d      = kill_pend_q;
        instr_d          = instr_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        wb_valid_d       = 1'b0;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        illegal_d        = 1'b0;

        req_ready_o      = 1'b0;
        issue_valid_o    = 1'b0;
        issue_instr_o    = '0;
        issue_id_o       = '0;
        issue_rs_o       = '0;
        issue_rs_valid_o = 2'b00;
        commit_valid_o   = 1'b0;
        commit_id_o      = '0;
        commit_kill_o    = 1'b0;
        result_ready_o   = 1'b0;
        timeout_o        = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o    = 1'b1;
                // Stale results are swallowed so they never stall the bus
                result_ready_o = active_q;
                kill_pend_d    = 1'b0;
                if (req_valid_i) begin
                    instr_d = req_instr_i;
                    rs1_d   = req_rs1_i;
                    rs2_d   = req_rs2_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid_o    = 1'b1;
                issue_instr_o    = instr_q;
                issue_id_o       = id_q;
                issue_rs_o       = {rs2_q, rs1_q};
                issue_rs_valid_o = XIF_RS_VALID_2OP;
                if (pipe_kill_i) begin
                    kill_pend_d = 1'b1;
                end
                if (issue_ready_i) begin
                    id_d          = id_q + 1'b1;
                    inflight_id_d = id_q;
                    if (issue_accept_i) begin
                        state_d = COMMIT;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            COMMIT: begin
                commit_id_o = inflight_id_q;
                // Kill takes priority over a simultaneous commit
                if (kill_pend_q || pipe_kill_i) begin
                    commit_valid_o = 1'b1;
                    commit_kill_o  = 1'b1;
                    state_d        = IDLE;
                end else if (pipe_commit_i) begin
                    commit_valid_o = 1'b1;
                    state_d        = WAIT_RES;
                end
            end
            WAIT_RES: begin
                result_ready_o = 1'b1;
                if (result_valid_i && (result_id_i == inflight_id_q)) begin
                    state_d    = IDLE;
                    wb_valid_d = result_we_i;
                    if (result_we_i) begin
                        wb_rd_d   = result_rd_i;
                        wb_data_d = result_data_i;
                    end
                end else if (wd_expire) begin
                    timeout_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            id_q          <= '0;
            inflight_id_q <= '0;
            kill_pend_q   <= 1'b0;
            instr_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            illegal_q     <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            inflight_id_q <= inflight_id_d;
            kill_pend_q   <= kill_pend_d;
            instr_q       <= instr_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            illegal_q     <= illegal_d;
            active_q      <= 1'b1;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign illegal_o  = illegal_q;

endmodule
